sev_seg_scan: RTL and testbench
===============================

Name: sev_seg_scan

Overview:
Parametrised, time-multiplexed N-digit seven-segment display driver. It is the successor of the single-digit hex decoder used by the clock display.
- Scans NUM_DIGITS common-anode digits and decodes 0-F per digit.
- Adds per-digit enable, decimal point, blink, leading-zero blanking, anti-ghost dead time and frame-synchronous input snapshotting.
- Sits between the time-keeping counters and the board pins (an/seg/dp).

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (legal 1..8)
SCAN_DIV, 100000, clock cycles per digit slot (must be > BLANK_CYCLES+1)
BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off (0 = no dead time)
BLINK_DIV, 50000000, clock cycles per blink half-period (>= 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  1 = display active; 0 = all outputs blank, counters keep running
digits  in  4*NUM_DIGITS  hex nibbles; digit i = digits[4i+3:4i], digit 0 rightmost
digit_en  in  NUM_DIGITS  per-digit enable; 0 = digit blanked
dp  in  NUM_DIGITS  decimal point request per digit (1 = lit)
blink_mask  in  NUM_DIGITS  1 = digit (and its dp) blanked during blink-off phase
lz_blank  in  1  1 = leading-zero blanking enabled
seg  out  7  active-low segments, seg[6]=a ... seg[0]=g
dp_n  out  1  active-low decimal point
an  out  NUM_DIGITS  active-low anodes, an[i] drives digit i
frame_tick  out  1  one-cycle pulse once per full scan frame

Behaviour:
- Reset (async, rst_n=0): div_cnt=0, idx=0, blink_cnt=0, blink_off=0, snapshot registers (digits/digit_en/dp/blink_mask/lz_blank)=0. Outputs: seg=7'b1111111, dp_n=1, an=all 1, frame_tick=0.
- Scan counters:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, idx advances mod NUM_DIGITS (NUM_DIGITS-1 -> 0).
  - NUM_DIGITS=1: idx is constant 0.
- Snapshot: all display inputs are captured in every cycle with div_cnt==0 && idx==0, including the first cycle after reset release. A value changing in that same cycle is captured. There is no tearing within a frame.
- frame_tick: registered, high exactly one cycle, the cycle after each snapshot load.
- Blink: blink_cnt counts 0..BLINK_DIV-1; blink_off toggles on each wrap. Blink is free-running and independent of scan.
- Leading-zero blank (uses snapshot values): digit i is suppressed when lz_blank=1, snapshot nibbles i..NUM_DIGITS-1 are all 0, and i != 0. Digit 0 is never LZ-suppressed. dp does not stop suppression.
- Digit visible = en && snap_digit_en[idx] && !(blink_off && snap_blink_mask[idx]) && !lz_suppressed(idx) && div_cnt >= BLANK_CYCLES.
- Output register (1-cycle latency from div_cnt/idx/en):
  - Visible: an = all 1 except an[idx]=0; seg = decode(snap nibble idx); dp_n = ~snap_dp[idx].
  - Not visible: an = all 1, seg = 7'b1111111, dp_n = 1.
- Decode table (active-low, abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- At most one anode is low in any cycle. On a slot change, the first output cycle of the new slot has all anodes high whenever BLANK_CYCLES>=1.
- en deasserted mid-slot: outputs blank on the next cycle; counters and snapshot are unaffected.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). The frame restarts at idx 0 with a fresh snapshot on the first clock after release.

Decomposition:
- Package sev_seg_pkg: 16-entry SEG_HEX decode constant, SEG_BLANK=7'b1111111, and the parameter legality limits.
- One natural sub-module: sev_seg_dec (combinational nibble -> segment lookup from the package), instanced once on the selected nibble.
- Counters, snapshot, LZ logic and output register live in sev_seg_scan.

Test Plan (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, BLINK_DIV=64):
- Reset release, digits=16'h1234, all enables 1, dp=0, blink_mask=0, lz_blank=0, en=1 -> frame_tick high on cycle 2 after release. Slot0 output cycles 3..8: an=1110, seg=1001100. Slot1: an=1101, seg=0000110. Period 32 cycles; 2 blank cycles per slot.
- digits=16'h0070, lz_blank=1 -> digits 3 and 2 blanked (an never 0111/1011). Digit1 shows 0001111, digit0 shows 0000001. With lz_blank=0, digit3 shows 0000001.
- digits changed 16'h1234->16'hABCD mid-frame -> remaining slots of the current frame still show 3,2,1 (old values). The next frame shows D,C,B,A (1000010, 0110001, 1100000, 0001000).
- blink_mask=4'b0001, dp=4'b0100 -> during blink_off half-periods, digit0 is never driven. Digit2 dp_n=0 in every frame; dp_n=1 in all other slots.
- en=0 for 20 cycles mid-slot -> an=1111, seg=1111111 from the next cycle. frame_tick cadence is unchanged (every 32 cycles).
- rst_n asserted asynchronously mid-slot with an=1011 -> an=1111, seg=1111111 with no clock edge. After release the scan resumes at digit0.

Source files
------------

// File: rtl/sev_seg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: hex glyphs and parameter limits.
// No logic; imported by sev_seg_dec and sev_seg_scan.
// No flow control.
package sev_seg_pkg;

    localparam int MIN_DIGITS = 1;
    localparam int MAX_DIGITS = 8;
    localparam int MIN_BLINK_DIV = 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low abcdefg glyphs; entry 0 is the rightmost element of the concatenation.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

endpackage

// File: rtl/sev_seg_dec.sv
// Nibble to active-low seven-segment glyph lookup.
// Latency: combinational.
// No flow control.
module sev_seg_dec
    import sev_seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nib];

endmodule

// File: rtl/sev_seg_scan.sv
// Time-multiplexed N-digit seven-segment driver with blink, LZ blanking, dead time and frame snapshot.
// Latency: one registered cycle from scan counters / en to an, seg, dp_n.
// No backpressure; free-running scan, inputs sampled once per frame.
module sev_seg_scan
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_DIV    = 50000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    if (NUM_DIGITS < MIN_DIGITS || NUM_DIGITS > MAX_DIGITS ||
        SCAN_DIV <= BLANK_CYCLES + 1 || BLINK_DIV < MIN_BLINK_DIV) begin : g_bad_param
        $error("sev_seg_scan: illegal parameter combination");
    end

    logic [DIV_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        idx;
    logic [BLK_W-1:0]        blink_cnt;
    logic                    blink_off;
    logic                    div_wrap;
    logic                    snap_load;
    logic                    snap_load_q;

    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_digit_en;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_blink_mask;
    logic                    snap_lz_blank;

    logic [4*NUM_DIGITS-1:0] cur_digits;
    logic [NUM_DIGITS-1:0]   cur_digit_en;
    logic [NUM_DIGITS-1:0]   cur_dp;
    logic [NUM_DIGITS-1:0]   cur_blink_mask;
    logic                    cur_lz_blank;

    logic [3:0]              sel_nib;
    logic [6:0]              sel_seg;
    logic                    upper_nz;
    logic                    lz_sup;
    logic                    visible;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [6:0]              seg_nxt;
    logic                    dp_n_nxt;

    assign div_wrap  = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign snap_load = (div_cnt == '0) && (idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) begin
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_digits     <= '0;
            snap_digit_en   <= '0;
            snap_dp         <= '0;
            snap_blink_mask <= '0;
            snap_lz_blank   <= 1'b0;
            snap_load_q     <= 1'b0;
            frame_tick      <= 1'b0;
        end else begin
            if (snap_load) begin
                snap_digits     <= digits;
                snap_digit_en   <= digit_en;
                snap_dp         <= dp;
                snap_blink_mask <= blink_mask;
                snap_lz_blank   <= lz_blank;
            end
            snap_load_q <= snap_load;
            frame_tick  <= snap_load_q;
        end
    end

    // The load cycle already shows the values being captured, so a frame never mixes old and new.
    assign cur_digits     = snap_load ? digits     : snap_digits;
    assign cur_digit_en   = snap_load ? digit_en   : snap_digit_en;
    assign cur_dp         = snap_load ? dp         : snap_dp;
    assign cur_blink_mask = snap_load ? blink_mask : snap_blink_mask;
    assign cur_lz_blank   = snap_load ? lz_blank   : snap_lz_blank;

    assign sel_nib = cur_digits[4*int'(idx) +: 4];

    always_comb begin
        upper_nz = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx) && cur_digits[4*j +: 4] != 4'h0) begin
                upper_nz = 1'b1;
            end
        end
    end

    assign lz_sup = cur_lz_blank && (idx != '0) && !upper_nz;

    assign visible = en
                  && cur_digit_en[idx]
                  && !(blink_off && cur_blink_mask[idx])
                  && !lz_sup
                  && (div_cnt >= DIV_W'(BLANK_CYCLES));

    sev_seg_dec u_dec (
        .nib (sel_nib),
        .seg (sel_seg)
    );

    always_comb begin
        an_nxt   = '1;
        seg_nxt  = SEG_BLANK;
        dp_n_nxt = 1'b1;
        if (visible) begin
            an_nxt[idx] = 1'b0;
            seg_nxt     = sel_seg;
            dp_n_nxt    = ~cur_dp[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an   <= '1;
            seg  <= SEG_BLANK;
            dp_n <= 1'b1;
        end else begin
            an   <= an_nxt;
            seg  <= seg_nxt;
            dp_n <= dp_n_nxt;
        end
    end

endmodule

// File: tb/tb_sev_seg_scan.sv
// Directed bench for sev_seg_scan with a frame-level reference model checked every cycle.
module tb_sev_seg_scan;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int BD = 64;
    localparam int FR = N * SD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [15:0]   digits;
    logic [3:0]    digit_en;
    logic [3:0]    dp;
    logic [3:0]    blink_mask;
    logic          lz_blank;
    logic [6:0]    seg;
    logic          dp_n;
    logic [3:0]    an;
    logic          frame_tick;

    int n_chk  = 0;
    int n_fail = 0;

    logic [6:0] hex_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    sev_seg_scan #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC),
        .BLINK_DIV    (BD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digits     (digits),
        .digit_en   (digit_en),
        .dp         (dp),
        .blink_mask (blink_mask),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .dp_n       (dp_n),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: position in the frame follows from the number of edges since reset release.
    int          t = 0;
    logic [15:0] s_dig = '0;
    logic [3:0]  s_en = '0, s_dp = '0, s_bm = '0;
    logic        s_lz = 1'b0;
    logic [3:0]  exp_an = 4'hF;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp_n = 1'b1;
    logic        exp_ft = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int  p, d, k;
        bit  boff, lzs, vis;
        if (!rst_n) begin
            t = 0;
            s_dig = '0; s_en = '0; s_dp = '0; s_bm = '0; s_lz = 1'b0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp_n = 1'b1; exp_ft = 1'b0;
        end else begin
            p = t;
            t = t + 1;
            d = p % SD;
            k = (p / SD) % N;
            if (p % FR == 0) begin
                s_dig = digits; s_en = digit_en; s_dp = dp; s_bm = blink_mask; s_lz = lz_blank;
            end
            boff = ((p / BD) % 2) == 1;
            lzs  = s_lz && (k != 0) && ((s_dig >> (4 * k)) == 16'h0);
            vis  = en && s_en[k] && !(boff && s_bm[k]) && !lzs && (d >= BC);
            exp_an   = vis ? ~(4'b0001 << k) : 4'hF;
            exp_seg  = vis ? hex_tab[s_dig[4*k +: 4]] : 7'h7F;
            exp_dp_n = vis ? ~s_dp[k] : 1'b1;
            exp_ft   = (p % FR == 1);
        end
    end

    bit cmp_on = 1'b0;

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_an", 32'(an), 32'(exp_an));
            chk("model_seg", 32'(seg), 32'(exp_seg));
            chk("model_dp_n", 32'(dp_n), 32'(exp_dp_n));
            chk("model_frame_tick", 32'(frame_tick), 32'(exp_ft));
            chk("one_anode_max", 32'($countones(~an) <= 1), 32'd1);
        end
    end

    initial begin
        rst_n      = 1'b1;
        en         = 1'b1;
        digits     = 16'h1234;
        digit_en   = 4'hF;
        dp         = 4'h0;
        blink_mask = 4'h0;
        lz_blank   = 1'b0;
        #1 rst_n = 1'b0;
        tick(3);
        cmp_on = 1'b1;
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_dp_n", 32'(dp_n), 32'd1);
        chk("reset_frame_tick", 32'(frame_tick), 32'd0);
        rst_n = 1'b1;

        tick(2);   // t=2
        chk("first_frame_tick", 32'(frame_tick), 32'd1);
        tick(1);   // t=3
        chk("slot0_an", 32'(an), 32'b1110);
        chk("slot0_seg", 32'(seg), 32'b1001100);
        tick(7);   // t=10
        chk("slot1_dead_an", 32'(an), 32'hF);
        tick(1);   // t=11
        chk("slot1_an", 32'(an), 32'b1101);
        chk("slot1_seg", 32'(seg), 32'b0000110);

        digits = 16'hABCD;
        tick(8);   // t=19
        chk("old_digit2_an", 32'(an), 32'b1011);
        chk("old_digit2_seg", 32'(seg), 32'b0010010);
        tick(15);  // t=34
        chk("frame_tick_period", 32'(frame_tick), 32'd1);
        tick(1);   // t=35
        chk("new_digit0_seg", 32'(seg), 32'b1000010);

        digits   = 16'h0070;
        lz_blank = 1'b1;
        tick(32);  // t=67
        chk("lz_d0_an", 32'(an), 32'b1110);
        chk("lz_d0_seg", 32'(seg), 32'b0000001);
        tick(8);   // t=75
        chk("lz_d1_seg", 32'(seg), 32'b0001111);
        tick(8);   // t=83
        chk("lz_d2_blank", 32'(an), 32'hF);
        tick(8);   // t=91
        chk("lz_d3_blank", 32'(an), 32'hF);
        lz_blank = 1'b0;
        tick(32);  // t=123
        chk("nolz_d3_an", 32'(an), 32'b0111);
        chk("nolz_d3_seg", 32'(seg), 32'b0000001);

        digits     = 16'h1234;
        blink_mask = 4'b0001;
        dp         = 4'b0100;
        tick(72);  // t=195
        chk("blink_off_d0", 32'(an), 32'hF);
        tick(16);  // t=211
        chk("dp_d2_an", 32'(an), 32'b1011);
        chk("dp_d2_dp_n", 32'(dp_n), 32'd0);
        tick(48);  // t=259
        chk("blink_on_d0", 32'(an), 32'b1110);
        chk("blink_on_d0_dp_n", 32'(dp_n), 32'd1);

        tick(1);   // t=260
        en = 1'b0;
        tick(1);   // t=261
        chk("en_off_an", 32'(an), 32'hF);
        chk("en_off_seg", 32'(seg), 32'h7F);
        tick(19);  // t=280
        en = 1'b1;
        tick(10);  // t=290
        chk("frame_tick_after_en", 32'(frame_tick), 32'd1);

        tick(17);  // t=307
        chk("pre_rst_an", 32'(an), 32'b1011);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_an", 32'(an), 32'hF);
        chk("async_rst_seg", 32'(seg), 32'h7F);
        chk("async_rst_dp_n", 32'(dp_n), 32'd1);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("resume_d0_an", 32'(an), 32'b1110);
        chk("resume_d0_seg", 32'(seg), 32'b1001100);

        digit_en = 4'b1011;
        tick(80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
